// File: rtl/host_xfer_arb_pkg.sv
// Shared types and constants for the host transfer arbiter.
package host_xfer_arb_pkg;

  localparam int unsigned HOST_DW = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SRQ  = 2'd1,
    ARB_XFER = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/host_xfer_arb_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping.
module arb_rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any
);

  logic found;

  // Scan offsets from rr_ptr; the first requester hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    any   = |req;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((32'(rr_ptr) + k) % NREQ) == i)) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/host_xfer_arb.sv
// Host readback arbiter: grants one streaming source at a time, raises
// host_srq, steers host word reads to the granted source.
// Optional watchdog abort enabled by defining HOST_ARB_WDOG_EN.
module host_xfer_arb
  import host_xfer_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned LEN_W       = 11,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic                      cpu_clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*LEN_W-1:0]     req_len,
  output logic [NREQ-1:0]           gnt,
  output logic                      host_srq,
  input  logic                      host_start,
  input  logic                      host_rd,
  output logic [HOST_DW-1:0]        host_dout,
  output logic [NREQ-1:0]           src_rd,
  input  logic [NREQ*HOST_DW-1:0]   src_dout,
  output logic [NREQ-1:0]           xfer_done,
  output logic                      xfer_abort,
  output logic                      busy
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   pick;
  logic              any;
  logic [LEN_W-1:0]  pick_len;
  logic [PTR_W-1:0]  rr_adv;
  logic [HOST_DW-1:0] sel_dout;
  logic              in_xfer;
  logic              wdog_hit;

  arb_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .any    (any)
  );

  // One-hot muxes: length of the picked source, data of the granted source,
  // and the pointer value just past the granted source.
  always_comb begin
    pick_len = '0;
    sel_dout = '0;
    rr_adv   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i])  pick_len = req_len[i*LEN_W +: LEN_W];
      if (gnt_q[i]) begin
        sel_dout = src_dout[i*HOST_DW +: HOST_DW];
        rr_adv   = PTR_W'((i + 1) % NREQ);
      end
    end
  end

`ifdef HOST_ARB_WDOG_EN
  logic [15:0] idle_q, idle_d;
  logic        wdog_act;

  // Idle counter runs only while waiting on the host; any host activity clears it.
  always_comb begin
    wdog_act = host_start | host_rd;
    wdog_hit = 1'b0;
    idle_d   = '0;
    if ((state_q == ARB_SRQ) || (state_q == ARB_XFER)) begin
      if (!wdog_act) begin
        if (idle_q == 16'(WDOG_CYCLES - 1)) wdog_hit = 1'b1;
        else                                idle_d   = idle_q + 16'd1;
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Next-state logic for the grant FSM, grant, word count and pointer.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          gnt_d   = pick;
          cnt_d   = pick_len;
          state_d = (pick_len == '0) ? ARB_DONE : ARB_SRQ;
        end
      end
      ARB_SRQ: begin
        if (wdog_hit) begin
          gnt_d    = '0;
          rr_ptr_d = rr_adv;
          state_d  = ARB_IDLE;
        end else if (host_start) begin
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (wdog_hit) begin
          gnt_d    = '0;
          rr_ptr_d = rr_adv;
          state_d  = ARB_IDLE;
        end else if (host_rd && (cnt_q != '0)) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        gnt_d    = '0;
        rr_ptr_d = rr_adv;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs decoded from state; reads outside XFER are over-reads and see nothing.
  always_comb begin
    in_xfer    = (state_q == ARB_XFER);
    gnt        = gnt_q;
    host_srq   = (state_q == ARB_SRQ);
    busy       = (state_q != ARB_IDLE);
    xfer_done  = (state_q == ARB_DONE) ? gnt_q : '0;
    xfer_abort = wdog_hit;
    src_rd     = in_xfer ? (gnt_q & {NREQ{host_rd}}) : '0;
    host_dout  = in_xfer ? sel_dout : '0;
  end

endmodule
